// File: rtl/div_iter_param.sv
// div_iter_param: multi-cycle radix-2 restoring divider, signed or unsigned, one quotient bit per clock.
// result_o packs {remainder, quotient}; div_zero_o flags a zero-divisor result.
module div_iter_param #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0, ZERO = 2'd1, ON = 2'd2, END = 2'd3;
    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd, dvs, rem, a_abs, b_abs, rem_next, q_next, q_fix, r_fix;
    logic [WIDTH:0]   shifted, diff;
    logic             neg_q, neg_r;
    // dvd shifts out dividend bits MSB first while quotient bits fill in from the LSB
    always_comb begin
        a_abs    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        b_abs    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        shifted  = {rem, dvd[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        q_next   = {dvd[WIDTH-2:0], ~diff[WIDTH]};
        q_fix    = neg_q ? -q_next : q_next;
        r_fix    = neg_r ? -rem_next : rem_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            result_o   <= '0;
            div_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i && !annul_i) begin
                    state <= (opdata2_i == '0) ? ZERO : ON;
                    dvd   <= a_abs;
                    dvs   <= b_abs;
                    rem   <= '0;
                    cnt   <= '0;
                    neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                end
                ZERO: begin
                    state      <= annul_i ? IDLE : END;
                    div_zero_o <= !annul_i;
                end
                ON: if (annul_i) begin
                    state <= IDLE;
                end else begin
                    dvd <= q_next;
                    rem <= rem_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state    <= END;
                        result_o <= {r_fix, q_fix};
                    end
                end
                END: if (!start_i) begin
                    state      <= IDLE;
                    result_o   <= '0;
                    div_zero_o <= 1'b0;
                end
            endcase
        end
    end
    assign busy_o  = (state == ZERO) || (state == ON);
    assign ready_o = (state == END);
endmodule

// File: tb/tb_div_iter_param.sv
// tb_div_iter_param: directed scoreboard bench for div_iter_param at WIDTH=32 and WIDTH=8.
module tb_div_iter_param;
    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          lat;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        s32 = 1'b0, an32 = 1'b0, sg32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] res32;
    logic        rdy32, bsy32, dz32;
    logic        s8 = 1'b0, an8 = 1'b0, sg8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] res8;
    logic        rdy8, bsy8, dz8;
    int          cur_w = 32;
    logic [63:0] o_res;
    logic        o_rdy, o_bsy, o_dz;
    int          checks = 0, failures = 0;
    exp_t        sb[$];

    div_iter_param #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start_i(s32), .annul_i(an32), .signed_div_i(sg32),
        .opdata1_i(a32), .opdata2_i(b32), .result_o(res32), .ready_o(rdy32),
        .busy_o(bsy32), .div_zero_o(dz32)
    );
    div_iter_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(s8), .annul_i(an8), .signed_div_i(sg8),
        .opdata1_i(a8), .opdata2_i(b8), .result_o(res8), .ready_o(rdy8),
        .busy_o(bsy8), .div_zero_o(dz8)
    );

    always #5 clk = ~clk;

    always_comb begin
        o_res = (cur_w == 8) ? {48'b0, res8} : res32;
        o_rdy = (cur_w == 8) ? rdy8 : rdy32;
        o_bsy = (cur_w == 8) ? bsy8 : bsy32;
        o_dz  = (cur_w == 8) ? dz8 : dz32;
    end

    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b, input bit sg);
        longint sa, sb_, q, r, m;
        m   = (longint'(1) << w) - 1;
        sa  = (sg && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb_ = (sg && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
        q   = sa / sb_;
        r   = sa % sb_;
        return 64'(((r & m) << w) | (q & m));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b, input bit sg, input bit st);
        cur_w = w;
        if (w == 8) begin
            a8 = a[7:0]; b8 = b[7:0]; sg8 = sg; s8 = st;
        end else begin
            a32 = a; b32 = b; sg32 = sg; s32 = st;
        end
    endtask

    task automatic run(input int w, input logic [31:0] a, input logic [31:0] b, input bit sg, input bit chg);
        exp_t e;
        int n;
        e.dz  = (b == 0);
        e.lat = (b == 0) ? 1 : w;
        e.res = (b == 0) ? 64'h0 : model(w, a, b, sg);
        sb.push_back(e);
        drive(w, a, b, sg, 1'b1);
        tick();
        chk("busy_at_accept", {63'b0, o_bsy}, 64'h1);
        if (chg) drive(w, $urandom, $urandom | 32'h1, ~sg, 1'b1);
        n = 0;
        while (!o_rdy && n < 200) begin
            tick();
            n++;
        end
        e = sb.pop_front();
        chk("latency", 64'(n), 64'(e.lat));
        chk("result", o_res, e.res);
        chk("div_zero", {63'b0, o_dz}, {63'b0, e.dz});
        chk("busy_at_ready", {63'b0, o_bsy}, 64'h0);
        tick();
        chk("result_held", o_res, e.res);
        chk("ready_held", {63'b0, o_rdy}, 64'h1);
        drive(w, a, b, sg, 1'b0);
        tick();
        chk("ready_clear", {63'b0, o_rdy}, 64'h0);
        chk("result_clear", o_res, 64'h0);
        chk("dz_clear", {63'b0, o_dz}, 64'h0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_res32", res32, 64'h0);
        chk("rst_flags32", {61'b0, rdy32, bsy32, dz32}, 64'h0);
        chk("rst_res8", {48'b0, res8}, 64'h0);
        chk("rst_flags8", {61'b0, rdy8, bsy8, dz8}, 64'h0);

        run(32, 32'd100, 32'd7, 1'b0, 1'b0);
        run(32, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        run(32, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run(8, 32'h80, 32'hFF, 1'b1, 1'b0);
        run(8, 32'hFF, 32'h01, 1'b0, 1'b0);
        run(8, 32'h85, 32'h07, 1'b1, 1'b0);
        run(32, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run(32, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run(32, 32'd1234, 32'd0, 1'b0, 1'b0);
        run(32, 32'hDEAD_BEEF, 32'h1234, 1'b0, 1'b1);

        // annul on the tenth ON cycle, dropping start so nothing re-accepts
        drive(32, 32'd1000, 32'd3, 1'b0, 1'b1);
        tick();
        repeat (9) tick();
        an32 = 1'b1;
        s32  = 1'b0;
        tick();
        an32 = 1'b0;
        chk("annul_busy", {63'b0, bsy32}, 64'h0);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("annul_no_ready", {63'b0, rdy32}, 64'h0);
        end
        run(32, 32'd1000, 32'd3, 1'b0, 1'b0);

        an32 = 1'b1;
        drive(32, 32'd50, 32'd5, 1'b0, 1'b1);
        tick();
        chk("start_annul_idle", {63'b0, bsy32}, 64'h0);
        an32 = 1'b0;
        s32  = 1'b0;

        drive(32, 32'd555, 32'd11, 1'b0, 1'b1);
        tick();
        repeat (4) tick();
        rst = 1'b1;
        s32 = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_res", res32, 64'h0);
        chk("midrst_flags", {61'b0, rdy32, bsy32, dz32}, 64'h0);
        run(32, 32'd555, 32'd11, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
